// File: rtl/ball_motion_if.sv
// ball_motion_if
//   Groups the ball kinematics stage's per-frame controls, collider flags
//   and position/velocity results into one bundle.
//   master : driver side (frame timing, collider, launch source); it drives
//            frame_start, landed, bounce, launch, vx_in, vy_in and observes
//            X, Y, vx, vy, airborne, pos_valid.
//   slave  : the ball_motion stage itself; the mirror of master.
interface ball_motion_if;
  logic              frame_start;
  logic              landed;
  logic              bounce;
  logic              launch;
  logic signed [7:0] vx_in;
  logic signed [7:0] vy_in;
  logic        [9:0] X;
  logic        [9:0] Y;
  logic signed [7:0] vx;
  logic signed [7:0] vy;
  logic              airborne;
  logic              pos_valid;

  modport master (
    output frame_start, landed, bounce, launch, vx_in, vy_in,
    input  X, Y, vx, vy, airborne, pos_valid
  );

  modport slave (
    input  frame_start, landed, bounce, launch, vx_in, vy_in,
    output X, Y, vx, vy, airborne, pos_valid
  );
endinterface

// File: rtl/ball_motion.sv
// ball_motion
//   Per-frame ball kinematics. Once per video frame the ball position is
//   advanced by its velocity, with integer gravity, wall reflection,
//   ceiling bounce and floor/terrain landing. While resting on terrain the
//   ball waits for a launch request.
//
// Ports
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : ball_motion_if.slave
//              frame_start  one-cycle pulse at start of vertical blank
//              landed       collider flag, terrain below ball
//              bounce       collider flag, terrain above ball
//              launch       one-cycle launch request (accepted only at rest)
//              vx_in/vy_in  signed launch velocity (negative vy = up)
//              X/Y          ball centre column/row
//              vx/vy        signed current velocity
//              airborne     high in every state except REST
//              pos_valid    one-cycle pulse when a new X/Y is committed
//
// Configuration
//   BALL_MOTION_DAMP_EN : when defined, wall and ceiling reflections halve
//                         the reflected speed ((-v)>>>1) so every impact
//                         loses energy. Undefined: full-magnitude reflection.
module ball_motion #(
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 100,
  parameter int RADIUS  = 4,
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int GRAVITY = 1,
  parameter int VY_MAX  = 8
) (
  input  logic         clk,
  input  logic         reset,
  ball_motion_if.slave bus
);

  typedef enum logic [2:0] {
    REST,
    FLY,
    COLLIDE,
    INTEGRATE,
    CLAMP
  } state_t;

  localparam logic signed [10:0] LO_LIM  = 11'(RADIUS);
  localparam logic signed [10:0] X_HI    = 11'(X_MAX - RADIUS);
  localparam logic signed [10:0] Y_HI    = 11'(Y_MAX - RADIUS);
  localparam logic signed [9:0]  GRAV_W  = 10'(GRAVITY);
  localparam logic signed [9:0]  VYMAX_W = 10'(VY_MAX);

  state_t            state, state_next;
  logic        [9:0] x_q, x_d, y_q, y_d;
  logic signed [7:0] vx_q, vx_d, vy_q, vy_d;
  logic signed [10:0] nx_q, nx_d, ny_q, ny_d;
  logic              land_s, land_d, bnc_s, bnc_d;
  logic              pos_valid_q, pos_valid_d;

  // Velocity reflection used for both wall and ceiling impacts.
  // Negating -128 would overflow, so the undamped form saturates to +127;
  // the damped form negates in 9 bits first so -128 yields +64.
  function automatic logic signed [7:0] reflect(input logic signed [7:0] v);
`ifdef BALL_MOTION_DAMP_EN
    logic signed [8:0] neg;
    neg     = -$signed({v[7], v});
    reflect = 8'(neg >>> 1);
`else
    reflect = (v == -8'sd128) ? 8'sd127 : -v;
`endif
  endfunction

  // Gravity step, computed wide so it can neither wrap past +127 nor
  // exceed the downward speed limit.
  function automatic logic signed [7:0] grav_add(input logic signed [7:0] v);
    logic signed [9:0] s;
    s = $signed({{2{v[7]}}, v}) + GRAV_W;
    if (s > VYMAX_W)
      grav_add = 8'(VY_MAX);
    else if (s < -10'sd128)
      grav_add = -8'sd128;
    else
      grav_add = s[7:0];
  endfunction

  always_comb begin
    state_next  = state;
    x_d         = x_q;
    y_d         = y_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    land_d      = land_s;
    bnc_d       = bnc_s;
    pos_valid_d = 1'b0;

    case (state)
      REST: begin
        vx_d = '0;
        vy_d = '0;
        // launch takes precedence over a coincident frame_start, which is
        // simply not looked at in this state
        if (bus.launch) begin
          vx_d       = bus.vx_in;
          vy_d       = bus.vy_in;
          land_d     = 1'b0;
          bnc_d      = 1'b0;
          state_next = FLY;
        end
      end

      FLY: begin
        // collider flags are held for the whole frame so a short pulse
        // during active video is not lost before the update
        land_d = land_s | bus.landed;
        bnc_d  = bnc_s | bus.bounce;
        if (bus.frame_start)
          state_next = COLLIDE;
      end

      COLLIDE: begin
        land_d = 1'b0;
        bnc_d  = 1'b0;
        // landing only counts while moving down; moving up through a
        // ledge ignores it
        if (land_s && !vy_q[7]) begin
          vx_d       = '0;
          vy_d       = '0;
          state_next = REST;
        end else begin
          if (bnc_s && vy_q[7])
            vy_d = reflect(vy_q);
          state_next = INTEGRATE;
        end
      end

      INTEGRATE: begin
        // position advances with the pre-gravity vy
        vy_d       = grav_add(vy_q);
        nx_d       = $signed({1'b0, x_q}) + $signed({{3{vx_q[7]}}, vx_q});
        ny_d       = $signed({1'b0, y_q}) + $signed({{3{vy_q[7]}}, vy_q});
        state_next = CLAMP;
      end

      CLAMP: begin
        pos_valid_d = 1'b1;
        state_next  = FLY;
        if (nx_q < LO_LIM) begin
          x_d  = LO_LIM[9:0];
          vx_d = reflect(vx_q);
        end else if (nx_q > X_HI) begin
          x_d  = X_HI[9:0];
          vx_d = reflect(vx_q);
        end else begin
          x_d = nx_q[9:0];
        end
        // floor contact overrides any wall reflection and parks the ball
        if (ny_q < LO_LIM) begin
          y_d  = LO_LIM[9:0];
          vy_d = '0;
        end else if (ny_q > Y_HI) begin
          y_d        = Y_HI[9:0];
          vx_d       = '0;
          vy_d       = '0;
          state_next = REST;
        end else begin
          y_d = ny_q[9:0];
        end
      end

      default: begin
        state_next = FLY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FLY;
      x_q         <= 10'(X_INIT);
      y_q         <= 10'(Y_INIT);
      vx_q        <= '0;
      vy_q        <= '0;
      nx_q        <= '0;
      ny_q        <= '0;
      land_s      <= 1'b0;
      bnc_s       <= 1'b0;
      pos_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      x_q         <= x_d;
      y_q         <= y_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      land_s      <= land_d;
      bnc_s       <= bnc_d;
      pos_valid_q <= pos_valid_d;
    end
  end

  assign bus.X         = x_q;
  assign bus.Y         = y_q;
  assign bus.vx        = vx_q;
  assign bus.vy        = vy_q;
  assign bus.airborne  = (state != REST);
  assign bus.pos_valid = pos_valid_q;

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion
//   Directed bench for ball_motion: reset values, free fall and gravity
//   saturation, landing, launch, ceiling bounce, flag priority, launch vs
//   frame_start, right wall reflection and floor clamp. Expected values are
//   hand-derived constants; the damped variant is selected with
//   BALL_MOTION_DAMP_EN exactly as in the design.
module tb_ball_motion;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;
  int   y_ceil;
  int   vx_wall;

  ball_motion_if bus ();

  ball_motion dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock and settle away from the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one cycle of inputs, then return them to idle
  task automatic applyStimulus(input logic fs, input logic ld, input logic bn,
                               input logic la, input logic signed [7:0] vxi,
                               input logic signed [7:0] vyi);
    bus.frame_start = fs;
    bus.landed      = ld;
    bus.bounce      = bn;
    bus.launch      = la;
    bus.vx_in       = vxi;
    bus.vy_in       = vyi;
    tick();
    bus.frame_start = 1'b0;
    bus.landed      = 1'b0;
    bus.bounce      = 1'b0;
    bus.launch      = 1'b0;
    bus.vx_in       = '0;
    bus.vy_in       = '0;
  endtask

  // frame_start pulse followed by the three update cycles; returns in the
  // cycle where a committed position is visible
  task automatic runFrame();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0);
    tick();
    tick();
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int ff_y[9];
    int ff_vy[9];
    ff_y  = '{101, 103, 106, 110, 115, 121, 128, 136, 144};
    ff_vy = '{2, 3, 4, 5, 6, 7, 8, 8, 8};
`ifdef BALL_MOTION_DAMP_EN
    y_ceil  = 101;
    vx_wall = -2;
`else
    y_ceil  = 103;
    vx_wall = -4;
`endif
    n_checks        = 0;
    n_fails         = 0;
    reset           = 1'b0;
    bus.frame_start = 1'b0;
    bus.landed      = 1'b0;
    bus.bounce      = 1'b0;
    bus.launch      = 1'b0;
    bus.vx_in       = '0;
    bus.vy_in       = '0;

    $display("[TB] reset values");
    tick();
    checkOutput("rst_X", bus.X, 320);
    checkOutput("rst_Y", bus.Y, 100);
    checkOutput("rst_vx", bus.vx, 0);
    checkOutput("rst_vy", bus.vy, 0);
    checkOutput("rst_airborne", bus.airborne, 1);
    checkOutput("rst_pos_valid", bus.pos_valid, 0);
    reset = 1'b1;

    $display("[TB] first frame and free fall");
    runFrame();
    checkOutput("f1_Y", bus.Y, 100);
    checkOutput("f1_X", bus.X, 320);
    checkOutput("f1_vy", bus.vy, 1);
    checkOutput("f1_pos_valid", bus.pos_valid, 1);
    tick();
    checkOutput("f1_pos_valid_drop", bus.pos_valid, 0);
    for (int i = 0; i < 9; i++) begin
      runFrame();
      checkOutput($sformatf("ff%0d_Y", i + 2), bus.Y, ff_y[i]);
      checkOutput($sformatf("ff%0d_vy", i + 2), bus.vy, ff_vy[i]);
    end

    $display("[TB] reset during update");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'sd0, 8'sd0);
    reset = 1'b0;
    #1;
    checkOutput("midrst_Y", bus.Y, 100);
    checkOutput("midrst_vy", bus.vy, 0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("midrst_pos_valid", bus.pos_valid, 0);

    $display("[TB] landing while falling");
    for (int i = 0; i < 5; i++) runFrame();
    checkOutput("pre_land_vy", bus.vy, 5);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0);
    tick();
    runFrame();
    checkOutput("land_airborne", bus.airborne, 0);
    checkOutput("land_vy", bus.vy, 0);
    checkOutput("land_Y", bus.Y, 110);
    checkOutput("land_pos_valid", bus.pos_valid, 0);
    runFrame();
    checkOutput("rest_ignores_frame_Y", bus.Y, 110);
    checkOutput("rest_ignores_frame_airborne", bus.airborne, 0);

    $display("[TB] launch and ceiling bounce");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'sd3, -8'sd6);
    checkOutput("launch_vx", bus.vx, 3);
    checkOutput("launch_vy", bus.vy, -6);
    checkOutput("launch_airborne", bus.airborne, 1);
    runFrame();
    checkOutput("up1_X", bus.X, 323);
    checkOutput("up1_Y", bus.Y, 104);
    checkOutput("up1_vy", bus.vy, -5);
    runFrame();
    checkOutput("up2_Y", bus.Y, 99);
    checkOutput("up2_vy", bus.vy, -4);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'sd0, 8'sd0);
    runFrame();
    checkOutput("ceil_X", bus.X, 329);
    checkOutput("ceil_Y", bus.Y, y_ceil);
`ifdef BALL_MOTION_DAMP_EN
    checkOutput("ceil_vy", bus.vy, 3);
`else
    checkOutput("ceil_vy", bus.vy, 5);
`endif

    $display("[TB] landed and bounce together");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0);
    runFrame();
    checkOutput("land2_airborne", bus.airborne, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'sd0, 8'sd2);
    checkOutput("launch2_vy", bus.vy, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'sd0, 8'sd0);
    runFrame();
    checkOutput("both_airborne", bus.airborne, 0);
    checkOutput("both_Y", bus.Y, y_ceil);
    checkOutput("both_vy", bus.vy, 0);

    $display("[TB] launch with coincident frame_start, rising through ledge");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'sd0, -8'sd3);
    tick();
    tick();
    tick();
    checkOutput("lf_airborne", bus.airborne, 1);
    checkOutput("lf_vy", bus.vy, -3);
    checkOutput("lf_Y", bus.Y, y_ceil);
    checkOutput("lf_pos_valid", bus.pos_valid, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0);
    runFrame();
    checkOutput("ledge_Y", bus.Y, y_ceil - 3);
    checkOutput("ledge_vy", bus.vy, -2);
    checkOutput("ledge_airborne", bus.airborne, 1);
    checkOutput("ledge_pos_valid", bus.pos_valid, 1);

    $display("[TB] right wall");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0);
    runFrame();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'sd113, 8'sd0);
    runFrame();
    checkOutput("hop1_X", bus.X, 433);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0);
    runFrame();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'sd100, 8'sd0);
    runFrame();
    runFrame();
    checkOutput("hop2_X", bus.X, 633);
    checkOutput("hop2_Y", bus.Y, 101);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'sd0, 8'sd0);
    runFrame();
    checkOutput("hop2_rest", bus.airborne, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'sd4, 8'sd0);
    runFrame();
    checkOutput("wall_X", bus.X, 635);
    checkOutput("wall_vx", bus.vx, vx_wall);
    checkOutput("wall_Y", bus.Y, 101);
    runFrame();
    checkOutput("wall_next_X", bus.X, 635 + vx_wall);

    $display("[TB] fall to floor");
    for (int i = 0; i < 80 && bus.airborne; i++) runFrame();
    checkOutput("floor_airborne", bus.airborne, 0);
    checkOutput("floor_Y", bus.Y, 475);
    checkOutput("floor_vx", bus.vx, 0);
    checkOutput("floor_vy", bus.vy, 0);
    checkOutput("floor_pos_valid", bus.pos_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
